// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types and constants for the LFSR stream slice.
//   lfsr_mode_e : feedback structure selector (Fibonacci / Galois)
//   fsm_e       : burst controller states
//   FIB_TAPS_n  : Fibonacci tap masks (bit i set = state[i] feeds the XOR)
//   GAL_POLY_n  : left-shifting Galois masks (polynomial without the x^n term)
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    // x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    localparam logic [7:0]  FIB_TAPS_8  = 8'hB8;
    localparam logic [15:0] FIB_TAPS_16 = 16'hB400;
    localparam logic [31:0] FIB_TAPS_32 = 32'h8020_0003;

    // x^8+x^4+x^3+x^2+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    localparam logic [7:0]  GAL_POLY_8  = 8'h1D;
    localparam logic [15:0] GAL_POLY_16 = 16'h6801;
    localparam logic [31:0] GAL_POLY_32 = 32'h0040_0007;

endpackage

// File: rtl/lfsr_stream_if.sv
// -----------------------------------------------------------------------------
// lfsr_stream_if
// Valid/ready output stream of the LFSR generator.
//   out_valid : word on out_data is offered
//   out_ready : consumer accepts the word this cycle
//   out_data  : current LFSR state
// master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface lfsr_stream_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// One combinational LFSR shift.
//   cur : present state
//   nxt : state after one shift (Fibonacci or Galois, chosen by MODE)
// -----------------------------------------------------------------------------
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               MODE     = 0,
    parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(FIB_TAPS_8),
    parameter logic [WIDTH-1:0] GAL_POLY = WIDTH'(GAL_POLY_8)
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (MODE == int'(LFSR_GAL)) begin : g_galois
            // Feedback is the bit shifted out; it folds the polynomial back in.
            assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? GAL_POLY : '0);
        end else begin : g_fibonacci
            assign nxt = {cur[WIDTH-2:0], ^(cur & FIB_TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_stream.sv
// -----------------------------------------------------------------------------
// lfsr_stream
// Pseudo-random word generator with burst control and a valid/ready output.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_seed, seed : load a new state while idle (seed 0 is replaced by 1)
//   start, len      : begin a burst of len words (len 0 = run until stop)
//   stop            : abort the running burst
//   out_if          : stream master (out_valid / out_ready / out_data)
//   busy            : burst in progress
//   done            : one-cycle pulse after the last word of a counted burst
//   word_cnt        : words accepted since the burst started
// Each accepted word advances the LFSR STEP shifts.
// -----------------------------------------------------------------------------
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               MODE     = 0,
    parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(FIB_TAPS_8),
    parameter logic [WIDTH-1:0] GAL_POLY = WIDTH'(GAL_POLY_8),
    parameter int               STEP     = 1,
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_seed,
    input  logic [WIDTH-1:0]  seed,
    input  logic              start,
    input  logic [15:0]       len,
    input  logic              stop,
    lfsr_stream_if.master     out_if,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_cnt
);

    // A zero seed would lock the register at zero forever.
    localparam logic [WIDTH-1:0] SAFE_SEED = (RST_SEED == '0) ? WIDTH'(1) : RST_SEED;

    fsm_e             state_q, state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] chain [STEP+1];
    logic [15:0]      len_q;
    logic [15:0]      cnt_q;
    logic             done_q;
    logic             hs;
    logic             last_word;
    logic             accept_load;
    logic             accept_start;

    // STEP single-shift stages in series give STEP shifts per accepted word.
    assign chain[0] = lfsr_q;
    generate
        for (genvar g = 0; g < STEP; g++) begin : g_chain
            lfsr_step #(
                .WIDTH   (WIDTH),
                .MODE    (MODE),
                .FIB_TAPS(FIB_TAPS),
                .GAL_POLY(GAL_POLY)
            ) u_step (
                .cur(chain[g]),
                .nxt(chain[g+1])
            );
        end
    endgenerate

    // load_seed has priority over start when both arrive together in IDLE.
    assign accept_load  = (state_q == ST_IDLE) && load_seed;
    assign accept_start = (state_q == ST_IDLE) && start && !load_seed;
    assign hs           = out_if.out_valid && out_if.out_ready;
    assign last_word    = (len_q != 16'd0) && ((cnt_q + 16'd1) == len_q);

    // NOTE: sequential state uses non-blocking assignments and resets on the
    // falling edge of rst_n, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_start)               state_d = ST_RUN;
            ST_RUN:  if ((hs && last_word) || stop)  state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_if.out_valid = (state_q == ST_RUN);
        busy             = (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SAFE_SEED;
            len_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= hs && last_word;
            if (accept_load) begin
                lfsr_q <= (seed == '0) ? WIDTH'(1) : seed;
            end else if (hs) begin
                lfsr_q <= chain[STEP];
            end
            if (accept_start) begin
                len_q <= len;
                cnt_q <= '0;
            end else if (hs) begin
                cnt_q <= cnt_q + 16'd1;   // wraps naturally at 16'hFFFF
            end
        end
    end

    assign out_if.out_data = lfsr_q;
    assign done            = done_q;
    assign word_cnt        = cnt_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream
// Three lfsr_stream instances share one stimulus:
//   0: Fibonacci taps B8, STEP 1   1: Galois poly 1D, STEP 1   2: Fibonacci B8, STEP 2
// Each scenario observes one instance (sel). Expected words are queued when
// the stimulus is driven and popped on every observed handshake.
// -----------------------------------------------------------------------------
module tb_lfsr_stream;

    logic        clk;
    logic        rst_n;
    logic        load_seed;
    logic [7:0]  seed;
    logic        start;
    logic [15:0] len;
    logic        stop;
    logic        ready;

    logic        v    [3];
    logic [7:0]  d    [3];
    logic        busy [3];
    logic        done [3];
    logic [15:0] wc   [3];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          sel     = 0;
    logic [7:0]  exp_q [$];

    lfsr_stream_if #(.WIDTH(8)) if_fib ();
    lfsr_stream_if #(.WIDTH(8)) if_gal ();
    lfsr_stream_if #(.WIDTH(8)) if_st2 ();

    assign if_fib.out_ready = ready;
    assign if_gal.out_ready = ready;
    assign if_st2.out_ready = ready;

    lfsr_stream u_fib (
        .clk(clk), .rst_n(rst_n), .load_seed(load_seed), .seed(seed),
        .start(start), .len(len), .stop(stop), .out_if(if_fib),
        .busy(busy[0]), .done(done[0]), .word_cnt(wc[0])
    );

    lfsr_stream #(.MODE(1), .GAL_POLY(8'h1D)) u_gal (
        .clk(clk), .rst_n(rst_n), .load_seed(load_seed), .seed(seed),
        .start(start), .len(len), .stop(stop), .out_if(if_gal),
        .busy(busy[1]), .done(done[1]), .word_cnt(wc[1])
    );

    lfsr_stream #(.STEP(2)) u_st2 (
        .clk(clk), .rst_n(rst_n), .load_seed(load_seed), .seed(seed),
        .start(start), .len(len), .stop(stop), .out_if(if_st2),
        .busy(busy[2]), .done(done[2]), .word_cnt(wc[2])
    );

    assign v[0] = if_fib.out_valid;  assign d[0] = if_fib.out_data;
    assign v[1] = if_gal.out_valid;  assign d[1] = if_gal.out_data;
    assign v[2] = if_st2.out_valid;  assign d[2] = if_st2.out_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Fibonacci step for taps B8 (bits 7,5,4,3).
    function automatic logic [7:0] fib8(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: score the handshake due at the coming posedge,
    // advance one cycle, and confirm a stalled word held still.
    task automatic tick();
        logic       stalled;
        logic [7:0] held;
        if (v[sel] && ready) begin
            if (exp_q.size() == 0) check("sb_extra_word", 32'(exp_q.size()), 32'd1);
            else                   check("sb_data", 32'(d[sel]), 32'(exp_q.pop_front()));
        end
        stalled = v[sel] && !ready;
        held    = d[sel];
        @(posedge clk);
        @(negedge clk);
        if (stalled) check("stall_hold", 32'(d[sel]), 32'(held));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; load_seed = 1'b0; seed = '0; start = 1'b0;
        len = '0; stop = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [15:0] n);
        start = 1'b1; len = n;
        tick();
        start = 1'b0;
    endtask

    // Run until busy drops or the cycle budget expires.
    task automatic run_to_idle(input int budget, input bit rand_ready);
        for (int i = 0; i < budget; i++) begin
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            load_seed = rand_ready && (i == 5);   // load during RUN must be ignored
            seed      = 8'hFF;
            tick();
            if (!busy[sel]) break;
        end
        load_seed = 1'b0;
        check("burst_end_busy", 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        logic [7:0] m;
        rst_n = 1'b1;
        #2;

        // ---- Fibonacci, len 5 ----
        sel = 0;
        do_reset();
        check("rst_valid", 32'(v[0]), 32'd0);
        check("rst_busy",  32'(busy[0]), 32'd0);
        check("rst_done",  32'(done[0]), 32'd0);
        check("rst_cnt",   32'(wc[0]), 32'd0);
        check("rst_data",  32'(d[0]), 32'h01);
        ready = 1'b1;
        start_burst(16'd5);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        exp_q.push_back(8'h08); exp_q.push_back(8'h11);
        run_to_idle(20, 1'b0);
        check("len5_done",   32'(done[0]), 32'd1);
        check("len5_cnt",    32'(wc[0]), 32'd5);
        check("len5_drain",  32'(exp_q.size()), 32'd0);
        tick();
        check("len5_done_pulse", 32'(done[0]), 32'd0);

        // ---- Fibonacci continuous: full period, then stop ----
        do_reset();
        ready = 1'b1;
        start_burst(16'd0);
        m = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back(m);
            m = fib8(m);
            tick();
        end
        check("period_data", 32'(d[0]), 32'h01);
        check("period_cnt",  32'(wc[0]), 32'd255);
        check("period_busy", 32'(busy[0]), 32'd1);
        stop = 1'b1;
        exp_q.push_back(m);
        tick();
        stop = 1'b0;
        check("stop_valid", 32'(v[0]), 32'd0);
        check("stop_busy",  32'(busy[0]), 32'd0);
        check("stop_done",  32'(done[0]), 32'd0);
        check("stop_adv",   32'(d[0]), 32'h02);
        tick();
        check("stop_no_done", 32'(done[0]), 32'd0);
        stop = 1'b1;                       // stop while idle does nothing
        tick();
        stop = 1'b0;
        check("idle_stop_data", 32'(d[0]), 32'h02);

        // ---- Galois, load + start together, then len 2 ----
        sel = 1;
        do_reset();
        load_seed = 1'b1; seed = 8'h80; start = 1'b1; len = 16'd2;
        tick();
        load_seed = 1'b0; start = 1'b0;
        check("gal_load_wins_busy", 32'(busy[1]), 32'd0);
        check("gal_load_data",      32'(d[1]), 32'h80);
        ready = 1'b1;
        start_burst(16'd2);
        exp_q.push_back(8'h80); exp_q.push_back(8'h1D);
        run_to_idle(10, 1'b0);
        check("gal_done",  32'(done[1]), 32'd1);
        check("gal_drain", 32'(exp_q.size()), 32'd0);

        // ---- STEP 2 Fibonacci, len 3 ----
        sel = 2;
        do_reset();
        ready = 1'b1;
        start_burst(16'd3);
        exp_q.push_back(8'h01); exp_q.push_back(8'h04); exp_q.push_back(8'h11);
        run_to_idle(10, 1'b0);
        check("st2_done",  32'(done[2]), 32'd1);
        check("st2_drain", 32'(exp_q.size()), 32'd0);

        // ---- Seed loading and random backpressure ----
        sel = 0;
        do_reset();
        load_seed = 1'b1; seed = 8'h5A;
        tick();
        check("load_5a", 32'(d[0]), 32'h5A);
        seed = 8'h00;
        tick();
        load_seed = 1'b0;
        check("load_zero_subst", 32'(d[0]), 32'h01);
        start_burst(16'd20);
        m = 8'h01;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(m);
            m = fib8(m);
        end
        run_to_idle(300, 1'b1);
        check("rand_done",  32'(done[0]), 32'd1);
        check("rand_cnt",   32'(wc[0]), 32'd20);
        check("rand_drain", 32'(exp_q.size()), 32'd0);

        // ---- Reset in the middle of a burst ----
        do_reset();
        ready = 1'b1;
        start_burst(16'd10);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(v[0]), 32'd0);
        check("mid_rst_busy",  32'(busy[0]), 32'd0);
        check("mid_rst_done",  32'(done[0]), 32'd0);
        check("mid_rst_cnt",   32'(wc[0]), 32'd0);
        check("mid_rst_data",  32'(d[0]), 32'h01);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_done", 32'(done[0]), 32'd0);
        end
        check("post_rst_data", 32'(d[0]), 32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
LFSR_STREAM -- requirements
Module: lfsr_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the LFSR register width (legal 4..32).
REQ-002 The block SHALL have parameter MODE, default 0, where 0 selects Fibonacci and 1 selects Galois.
REQ-003 The block SHALL have parameter FIB_TAPS, default 8'hB8, a WIDTH-bit mask of the state bits XORed into the Fibonacci feedback.
REQ-004 The block SHALL have parameter GAL_POLY, default 8'h1D, a WIDTH-bit Galois XOR mask with bit 0 set.
REQ-005 The block SHALL have parameter STEP, default 1, giving LFSR shifts per accepted word (legal 1..WIDTH).
REQ-006 The block SHALL have parameter RST_SEED, default 1, giving the state after reset (nonzero).
REQ-007 The block SHALL have ports: clk in 1, clock; rst_n in 1, reset (asynchronous, active-low).
REQ-008 The block SHALL have ports: load_seed in 1, load request; seed in WIDTH, seed value.
REQ-009 The block SHALL have ports: start in 1, begin burst; len in 16, burst word count (0 = continuous); stop in 1, abort.
REQ-010 The block SHALL have ports: out_valid out 1; out_ready in 1; out_data out WIDTH; busy out 1; done out 1 (one-cycle pulse); word_cnt out 16.

Function
REQ-011 The Fibonacci step SHALL be fb = XOR of state bits where FIB_TAPS=1, then next = {state[WIDTH-2:0], fb}.
REQ-012 The Galois step SHALL be msb = state[WIDTH-1], then next = {state[WIDTH-2:0],1'b0} XOR (msb ? GAL_POLY : 0).
REQ-013 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-014 In IDLE, load_seed SHALL load seed into state on the next edge, substituting 1 for seed==0.
REQ-015 load_seed SHALL be ignored in RUN.
REQ-016 In IDLE, start SHALL move the FSM to RUN, latch len, clear word_cnt, and set busy=1 on the next edge.
REQ-017 If load_seed and start are asserted together in IDLE, load_seed SHALL win and start SHALL be ignored.
REQ-018 start SHALL be ignored in RUN.
REQ-019 In RUN, out_valid SHALL be 1 and out_data SHALL equal the current state; the first word after start SHALL be the state held at start.
REQ-020 On a handshake (out_valid & out_ready), state SHALL advance STEP steps and word_cnt SHALL increment on the same edge.
REQ-021 Without a handshake, state and out_data SHALL hold stable.
REQ-022 word_cnt SHALL wrap from 16'hFFFF to 0.
REQ-023 If len != 0, the handshake that makes word_cnt equal len SHALL return the FSM to IDLE and pulse done for one cycle.
REQ-024 If len == 0, the FSM SHALL stay in RUN until stop is asserted.
REQ-025 stop in RUN SHALL return the FSM to IDLE next cycle with out_valid=0 and no done pulse; a handshake in the same cycle SHALL still complete and advance state.
REQ-026 stop SHALL have no effect in IDLE.
REQ-027 In IDLE, out_valid and busy SHALL be 0 and out_data SHALL show the current state.
REQ-028 The all-zero state SHALL be unreachable by construction.

Reset
REQ-029 While rst_n=0, the block SHALL force state=RST_SEED, FSM=IDLE, out_valid=0, busy=0, done=0, word_cnt=0, and latched len=0.
REQ-030 Reset SHALL abort a burst mid-operation without producing a done pulse.

Structure
REQ-031 Package lfsr_pkg SHALL hold the mode enum (LFSR_FIB, LFSR_GAL) and standard tap/poly constants for widths 8, 16, and 32.
REQ-032 A combinational sub-module lfsr_step (one shift, parametrised by WIDTH, MODE, and masks) SHALL be instantiated STEP times in a chain.

Verification
REQ-033 The bench SHALL check: W=8, Fib, taps B8, reset, start len=5, ready=1 -> out_data 01,02,04,08,11, then done pulse and busy=0.
REQ-034 The bench SHALL check: same configuration, len=0, ready=1 -> state returns to 01 after exactly 255 handshakes; stop -> IDLE next cycle.
REQ-035 The bench SHALL check: W=8, Galois, poly 1D, load_seed 80, start len=2 -> out_data 80, then 1D.
REQ-036 The bench SHALL check: STEP=2, Fib B8, seed 01, len=3 -> out_data 01, 04, 11.
REQ-037 The bench SHALL check: out_ready toggled randomly -> out_data stable while stalled and no word skipped or repeated; load_seed 00 -> state 01; load_seed in RUN -> ignored.
REQ-038 The bench SHALL check: rst_n pulsed low mid-burst -> all outputs at reset values, no done pulse, state=RST_SEED.
